// File: rtl/usb_rx_deserializer.sv
// usb_rx_deserializer: NRZI decode, SYNC hunt, bit destuffing and LSB-first byte assembly
module usb_rx_deserializer #(
  parameter int         DATA_WIDTH   = 8,
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LEN    = 6
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  shift_enable,
  input  logic                  serial_in,
  input  logic                  eop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  sync_found,
  output logic                  busy,
  output logic                  done,
  output logic                  stuff_err,
  output logic                  byte_err
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam logic [BW-1:0] BITS_MAX = BW'(DATA_WIDTH);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
  typedef enum logic {HUNT, RECEIVE} state_t;
  state_t                  state_q;
  logic                    line_prev_q;
  logic [7:0]              win_q;
  logic [DATA_WIDTH-1:0]   shreg_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic [BW-1:0]           bit_cnt_q;
  logic [OW-1:0]           ones_cnt_q;
  logic                    data_valid_q;
  logic                    sync_found_q;
  logic                    done_q;
  logic                    stuff_err_q;
  logic                    byte_err_q;
  logic                    dbit;
  logic [7:0]              win_d;
  logic [DATA_WIDTH-1:0]   shreg_d;
  logic [BW-1:0]           bit_cnt_d;
  assign dbit      = serial_in == line_prev_q;
  assign win_d     = {dbit, win_q[7:1]};
  assign shreg_d   = {dbit, shreg_q[DATA_WIDTH-1:1]};
  assign bit_cnt_d = bit_cnt_q + 1'b1;
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign sync_found = sync_found_q;
  assign busy       = state_q == RECEIVE;
  assign done       = done_q;
  assign stuff_err  = stuff_err_q;
  assign byte_err   = byte_err_q;
  // Receiver FSM: eop takes priority over a same-cycle strobe, though the line history still advances
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= HUNT;
      line_prev_q  <= 1'b1;
      win_q        <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      sync_found_q <= 1'b0;
      done_q       <= 1'b0;
      stuff_err_q  <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      sync_found_q <= 1'b0;
      done_q       <= 1'b0;
      stuff_err_q  <= 1'b0;
      byte_err_q   <= 1'b0;
      if (shift_enable) line_prev_q <= serial_in;
      if (state_q == RECEIVE && eop) begin
        done_q     <= 1'b1;
        byte_err_q <= bit_cnt_q != '0;
        state_q    <= HUNT;
        win_q      <= '0;
        bit_cnt_q  <= '0;
        ones_cnt_q <= '0;
      end else if (shift_enable && state_q == HUNT) begin
        win_q <= win_d;
        if (win_d == SYNC_PATTERN) begin
          state_q      <= RECEIVE;
          sync_found_q <= 1'b1;
          ones_cnt_q   <= OW'(1);
          bit_cnt_q    <= '0;
        end
      end else if (shift_enable) begin
        if (ones_cnt_q == ONES_MAX) begin
          ones_cnt_q <= '0;
          if (dbit) begin
            stuff_err_q <= 1'b1;
            state_q     <= HUNT;
            win_q       <= '0;
            bit_cnt_q   <= '0;
          end
        end else begin
          shreg_q    <= shreg_d;
          ones_cnt_q <= dbit ? ones_cnt_q + 1'b1 : '0;
          bit_cnt_q  <= bit_cnt_d == BITS_MAX ? '0 : bit_cnt_d;
          if (bit_cnt_d == BITS_MAX) begin
            data_out_q   <= shreg_d;
            data_valid_q <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_usb_rx_deserializer.sv
// tb_usb_rx_deserializer: transmitter-side model feeds NRZI/stuffed packets, scoreboard checks pulses
module tb_usb_rx_deserializer;
  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       shift_enable = 1'b0;
  logic       serial_in = 1'b1;
  logic       eop = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, sync_found, busy, done, stuff_err, byte_err;
  usb_rx_deserializer dut (
    .clk(clk), .RST(RST), .shift_enable(shift_enable), .serial_in(serial_in), .eop(eop),
    .data_out(data_out), .data_valid(data_valid), .sync_found(sync_found), .busy(busy),
    .done(done), .stuff_err(stuff_err), .byte_err(byte_err)
  );
  always #5 clk = ~clk;
  localparam int K_DATA = 0, K_SYNC = 1, K_DONE = 2, K_STUFF = 3;
  typedef struct { int kind; logic [7:0] val; } ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic line = 1'b1;
  int run = 0;
  int nbits = 0;
  logic [7:0] last_byte = 8'h00;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_ev(input int kind, input logic [7:0] val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0h expected none at %0t", kind, val, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val) begin
        errors++;
        $display("FAIL event: got kind %0d val %0h expected kind %0d val %0h at %0t", kind, val, e.kind, e.val, $time);
      end
    end
  endtask
  always @(negedge clk) if (!RST) begin
    if (data_valid) expect_ev(K_DATA, data_out);
    if (sync_found) expect_ev(K_SYNC, 8'h00);
    if (done) expect_ev(K_DONE, {7'b0, byte_err});
    if (byte_err && !done) expect_ev(K_DONE, 8'hEE);
    if (stuff_err) expect_ev(K_STUFF, 8'h00);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_dec(input logic b);
    line = b ? line : ~line;
    serial_in = line;
    shift_enable = 1'b1;
    tick();
    shift_enable = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      serial_in = 1'($urandom);
      tick();
    end
  endtask
  task automatic send_data_bit(input logic b);
    if (run == 6) begin
      send_dec(1'b0);
      run = 0;
    end
    send_dec(b);
    run = b ? run + 1 : 0;
    nbits = (nbits + 1) % 8;
  endtask
  task automatic send_sync;
    exp_q.push_back('{K_SYNC, 8'h00});
    repeat (7) send_dec(1'b0);
    send_dec(1'b1);
    run = 1;
    nbits = 0;
    chk("busy_after_sync", 32'(busy), 32'd1);
  endtask
  task automatic send_byte(input logic [7:0] v);
    exp_q.push_back('{K_DATA, v});
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    last_byte = v;
  endtask
  task automatic send_eop(input logic strobe);
    exp_q.push_back('{K_DONE, 8'(nbits != 0)});
    eop = 1'b1;
    shift_enable = strobe;
    if (strobe) begin
      line = 1'($urandom);
      serial_in = line;
    end
    tick();
    eop = 1'b0;
    shift_enable = 1'b0;
    run = 0;
    nbits = 0;
    chk("busy_after_eop", 32'(busy), 32'd0);
    chk("data_out_hold", 32'(data_out), 32'(last_byte));
  endtask
  task automatic do_reset;
    RST = 1'b1;
    shift_enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      serial_in = 1'(i);
      tick();
    end
    RST = 1'b0;
    shift_enable = 1'b0;
    serial_in = 1'b1;
    line = 1'b1;
    run = 0;
    nbits = 0;
    last_byte = 8'h00;
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_pulses", {26'd0, data_valid, sync_found, done, stuff_err, byte_err, busy}, 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    send_sync();
    send_byte(8'hB7);
    send_eop(1'b0);
    send_sync();
    send_byte(8'hFF);
    send_eop(1'b0);
    send_sync();
    repeat (5) send_data_bit(1'b1);
    exp_q.push_back('{K_STUFF, 8'h00});
    send_dec(1'b1);
    run = 0;
    nbits = 0;
    chk("busy_after_stuff_err", 32'(busy), 32'd0);
    chk("no_data_on_stuff_err", 32'(data_out), 32'hFF);
    send_sync();
    send_byte(8'h3C);
    send_eop(1'b0);
    send_sync();
    send_byte(8'hB7);
    repeat (3) send_data_bit(1'($urandom));
    send_eop(1'b1);
    send_sync();
    repeat (4) send_data_bit(1'($urandom));
    do_reset();
    send_sync();
    send_byte(8'hA5);
    send_eop(1'b0);
    for (int p = 0; p < 25; p++) begin
      send_sync();
      repeat ($urandom_range(0, 3)) send_byte($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom));
      repeat ($urandom_range(0, 7)) send_data_bit(1'($urandom));
      send_eop(1'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (5) tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
